// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: sequencer for the channel-accumulation vector adder.
// It drives the adder's ena and input zero-select so that num_ch partial-sum
// beats are summed per tile. Each finished tile is presented downstream with
// a valid/ready handshake. The controller walks num_tiles tiles per accepted
// start command.
//
// Optional feature macro: ACC_SEQ_PERF_EN (stall performance counter).
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high. The input beat side is in_valid/in_ready, and
// in_ready is high only in ACC. The output tile side is out_valid/out_ready,
// and out_valid is high only in RES and stays high until out_ready is seen.
// The controller never drops or changes a presented tile while it waits.
//
// Adder control encoding (ena, sel_zero):
//   0,0 load input vector
//   1,0 accumulate input vector
//   1,1 hold (c + 0)

module acc_seq_ctrl #(
  parameter int CH_W   = 8,
  parameter int TILE_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_num_ch,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              add_ena,
  output logic              add_sel_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CH_W-1:0]   ch_idx,
  output logic [TILE_W-1:0] tile_idx,
  output logic [31:0]       stall_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RES  = 2'd2
  } state_t;

  localparam logic [CH_W-1:0]   CH_ONE   = {{(CH_W-1){1'b0}}, 1'b1};
  localparam logic [TILE_W-1:0] TILE_ONE = {{(TILE_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_num_ch;
  logic [TILE_W-1:0] r_num_tiles;
  logic [CH_W-1:0]   r_ch_idx;
  logic [TILE_W-1:0] r_tile_idx;
  logic              r_done;

  logic w_start_ok;
  logic w_beat;
  logic w_ch_last;
  logic w_tile_last;
  logic w_out_hs;

  // A start is taken only from IDLE and only with non-zero geometry.
  assign w_start_ok  = (r_state == ST_IDLE) && start &&
                       (cfg_num_ch != '0) && (cfg_num_tiles != '0);
  assign w_beat      = (r_state == ST_ACC) && in_valid;
  // The counters compare against the latched config, never the live inputs.
  assign w_ch_last   = (r_ch_idx == (r_num_ch - CH_ONE));
  assign w_tile_last = (r_tile_idx == (r_num_tiles - TILE_ONE));
  assign w_out_hs    = (r_state == ST_RES) && out_ready;

  // Next-state and adder/handshake outputs; hold encoding is the default.
  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    add_ena      = 1'b1;
    add_sel_zero = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          add_sel_zero = 1'b0;
          // The first beat of a tile loads and the later beats accumulate.
          add_ena      = (r_ch_idx != '0);
          if (w_ch_last) begin
            w_state_nxt = ST_RES;
          end
        end
      end
      ST_RES: begin
        out_valid = 1'b1;
        out_last  = w_tile_last;
        if (out_ready) begin
          w_state_nxt = w_tile_last ? ST_IDLE : ST_ACC;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latched command geometry. It changes only when a start is accepted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_num_ch    <= '0;
      r_num_tiles <= '0;
    end else if (w_start_ok) begin
      r_num_ch    <= cfg_num_ch;
      r_num_tiles <= cfg_num_tiles;
    end
  end

  // Beat index within the current tile.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ch_idx <= '0;
    end else if (w_start_ok) begin
      r_ch_idx <= '0;
    end else if (w_beat) begin
      r_ch_idx <= w_ch_last ? '0 : (r_ch_idx + CH_ONE);
    end
  end

  // Tile index. It advances when a non-final tile is handshaken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tile_idx <= '0;
    end else if (w_start_ok) begin
      r_tile_idx <= '0;
    end else if (w_out_hs && !w_tile_last) begin
      r_tile_idx <= r_tile_idx + TILE_ONE;
    end
  end

  // Done pulse in the cycle after the final tile handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_out_hs && w_tile_last;
    end
  end

`ifdef ACC_SEQ_PERF_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall_evt;

  assign w_stall_evt = ((r_state == ST_ACC) && !in_valid) ||
                       ((r_state == ST_RES) && !out_ready);

  // Saturating stall counter. It is cleared by an accepted start and frozen in IDLE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign ch_idx    = r_ch_idx;
  assign tile_idx  = r_tile_idx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl. The driver tasks issue directed commands and push
// the expected tile results {sum, tile_idx, last} into exp_q. A monitor pops
// and compares an entry on every output handshake. A behavioural adder is
// driven by add_ena/add_sel_zero, so the sums show whether the sequencing is
// right.

module tb_acc_seq_ctrl;

  localparam int CH_W   = 8;
  localparam int TILE_W = 16;
  localparam int EW     = 16 + TILE_W + 1;

  logic              clk;
  logic              rstn;
  logic              start;
  logic [CH_W-1:0]   cfg_num_ch;
  logic [TILE_W-1:0] cfg_num_tiles;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic              add_ena;
  logic              add_sel_zero;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [CH_W-1:0]   ch_idx;
  logic [TILE_W-1:0] tile_idx;
  logic [31:0]       stall_cnt;
  logic [1:0]        dbg_state;

  logic [15:0]       in_data;
  logic [15:0]       acc;

  logic [EW-1:0]     exp_q[$];
  int                n_checks;
  int                n_pass;
  int                done_cnt;

  acc_seq_ctrl #(.CH_W(CH_W), .TILE_W(TILE_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .cfg_num_ch    (cfg_num_ch),
    .cfg_num_tiles (cfg_num_tiles),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .add_ena       (add_ena),
    .add_sel_zero  (add_sel_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .ch_idx        (ch_idx),
    .tile_idx      (tile_idx),
    .stall_cnt     (stall_cnt),
    .dbg_state     (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder attached to the controller outputs.
  always @(posedge clk) begin
    if (!rstn) acc <= '0;
    else if (!add_ena) acc <= add_sel_zero ? 16'd0 : in_data;
    else acc <= acc + (add_sel_zero ? 16'd0 : in_data);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: compare each handshaken tile with the head of exp_q.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("tile_unexpected", {31'd0, acc, tile_idx, out_last}, 64'h1_0000_0000);
      end else begin
        chk("tile_result", {31'd0, acc, tile_idx, out_last}, {31'd0, exp_q.pop_front()});
      end
    end
    if (done) done_cnt++;
  end

  // Driver tasks.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int nch, input int ntl);
    start = 1'b1;
    cfg_num_ch = CH_W'(nch);
    cfg_num_tiles = TILE_W'(ntl);
    cyc();
    start = 1'b0;
  endtask

  task automatic beat(input int data, input int exp_ch, input logic exp_ena);
    in_valid = 1'b1;
    in_data = 16'(data);
    #1;
    chk("beat_add_ena", add_ena, exp_ena);
    chk("beat_sel_zero", add_sel_zero, 0);
    chk("beat_in_ready", in_ready, 1);
    chk("beat_ch_idx", ch_idx, exp_ch);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic gap(input int exp_ch);
    in_valid = 1'b0;
    #1;
    chk("gap_add_ena", add_ena, 1);
    chk("gap_sel_zero", add_sel_zero, 1);
    chk("gap_in_ready", in_ready, 1);
    cyc();
    chk("gap_ch_frozen", ch_idx, exp_ch);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_add_ena", add_ena, 1);
    chk("rst_sel_zero", add_sel_zero, 1);
    chk("rst_ch_idx", ch_idx, 0);
    chk("rst_tile_idx", tile_idx, 0);
    chk("rst_stall", stall_cnt, 0);
  endtask

  function automatic logic [EW-1:0] mk(input int sum, input int tile, input logic last);
    return {16'(sum), TILE_W'(tile), last};
  endfunction

  initial begin
    n_checks = 0; n_pass = 0; done_cnt = 0;
    rstn = 1'b0; start = 1'b0; cfg_num_ch = '0; cfg_num_tiles = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cyc(); cyc();
    chk_reset_outputs();
    rstn = 1'b1;
    cyc();

    // num_ch=3, one tile: load, add, add, then result 1+2+3.
    out_ready = 1'b1;
    exp_q.push_back(mk(6, 0, 1'b1));
    do_start(3, 1);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 3; i++) beat(i + 1, i, i != 0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_last", out_last, 1);
    chk("t1_res_hold_ena", add_ena, 1);
    chk("t1_res_hold_sel", add_sel_zero, 1);
    cyc();
    chk("t1_done", done, 1);
    chk("t1_busy_after", busy, 0);
    cyc();
    chk("t1_done_single", done, 0);

    // num_ch=4 with two idle gaps: sum 5+6+7+8.
    exp_q.push_back(mk(26, 0, 1'b1));
    do_start(4, 1);
    beat(5, 0, 1'b0);
    gap(1);
    beat(6, 1, 1'b1);
    gap(2);
    beat(7, 2, 1'b1);
    beat(8, 3, 1'b1);
    chk("t2_out_valid", out_valid, 1);
    cyc();
    chk("t2_done", done, 1);

    // num_ch=1, three tiles, out_ready low two cycles per tile.
    out_ready = 1'b0;
    do_start(1, 3);
    for (int t = 0; t < 3; t++) begin
      beat(10 * (t + 1), 0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        if (t == 1 && k == 0) begin
          start = 1'b1; cfg_num_ch = 8'd5; cfg_num_tiles = 16'd5;
        end
        chk("t3_out_valid", out_valid, 1);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_tile_idx", tile_idx, t);
        chk("t3_out_last", out_last, t == 2);
        cyc();
        start = 1'b0;
      end
      exp_q.push_back(mk(10 * (t + 1), t, t == 2));
      out_ready = 1'b1;
      chk("t3_out_valid_hs", out_valid, 1);
      cyc();
      out_ready = 1'b0;
    end
    chk("t3_done", done, 1);
    chk("t3_idle", busy, 0);

    // Zero-geometry starts are ignored.
    do_start(0, 2);
    chk("t4_zero_ch_busy", busy, 0);
    do_start(2, 0);
    chk("t4_zero_tiles_busy", busy, 0);
    cyc();
    chk("t4_done_count", done_cnt, 3);

    // Reset in the middle of a tile, then a clean restart.
    out_ready = 1'b1;
    do_start(4, 1);
    beat(1, 0, 1'b0);
    beat(2, 1, 1'b1);
    chk("t5_ch_idx_pre", ch_idx, 2);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    chk_reset_outputs();
    exp_q.push_back(mk(7, 0, 1'b1));
    do_start(2, 1);
    beat(3, 0, 1'b0);
    beat(4, 1, 1'b1);
    cyc();
    chk("t5_done", done, 1);

    // Stall counting: two input gaps and three out_ready-low cycles.
    out_ready = 1'b0;
    exp_q.push_back(mk(19, 0, 1'b1));
    do_start(2, 1);
    gap(0);
    gap(0);
    beat(9, 0, 1'b0);
    beat(10, 1, 1'b1);
    for (int k = 0; k < 3; k++) cyc();
    out_ready = 1'b1;
    cyc();
    chk("t6_done", done, 1);
`ifdef ACC_SEQ_PERF_EN
    chk("t6_stall_5", stall_cnt, 5);
    cyc();
    chk("t6_stall_hold", stall_cnt, 5);
`else
    chk("t6_stall_0", stall_cnt, 0);
    cyc();
    chk("t6_stall_hold", stall_cnt, 0);
`endif
    exp_q.push_back(mk(7, 0, 1'b1));
    do_start(1, 1);
    chk("t6_stall_cleared", stall_cnt, 0);
    beat(7, 0, 1'b0);
    cyc();
    chk("t6_done2", done, 1);
    cyc(); cyc();

    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_done_count", done_cnt, 6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
- Sequencer for the channel-accumulation vector adder in the CONV path. The adder has an ena input: ena=0 loads the input vector, ena=1 adds the input vector to its register.
- Drives the adder's ena plus a zero-select on the adder's input mux, so that NUM_CH partial-sum vectors per output tile are summed, stalls hold the sum, and each finished tile is presented downstream with a valid/ready handshake.
- Iterates over NUM_TILES tiles per start command.

Parameters:
- CH_W, 8, width of channel-count config and ch_idx
- TILE_W, 16, width of tile-count config and tile_idx

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start  in  1  command pulse; accepted only in IDLE
- cfg_num_ch  in  CH_W  partial-sum beats per tile; latched on start
- cfg_num_tiles  in  TILE_W  tiles per command; latched on start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last tile is handshaken
- in_valid  in  1  partial-sum vector present on the adder input
- in_ready  out  1  controller accepts the beat
- add_ena  out  1  to the adder's ena input
- add_sel_zero  out  1  1 = adder input mux selects the all-zero vector
- out_valid  out  1  adder register holds a finished tile sum
- out_ready  in  1  downstream accepts the tile
- out_last  out  1  current output is the final tile of the command
- ch_idx  out  CH_W  index of the next beat within the tile
- tile_idx  out  TILE_W  index of the current tile
- stall_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (rstn=0 sampled at posedge) applies from any state, including mid-tile:
  - state=IDLE, counters 0, latched config 0.
  - Outputs: busy=0, done=0, in_ready=0, out_valid=0, out_last=0, add_ena=1, add_sel_zero=1, ch_idx=0, tile_idx=0, stall_cnt=0.
  - The adder clears itself from its own reset.
- Hold rule: in any cycle with no load or add, the controller drives add_ena=1 and add_sel_zero=1, so the adder register is unchanged (c+0).
- States: IDLE, ACC, RES.
- IDLE:
  - in_ready=0, out_valid=0, hold rule applies.
  - start=1 with cfg_num_ch!=0 and cfg_num_tiles!=0: latch both config values, ch_idx=0, tile_idx=0, go to ACC.
  - start=1 with either config value 0: ignored, stay in IDLE, no done pulse.
- ACC:
  - in_ready=1; add_ena and add_sel_zero are combinational from in_valid and ch_idx.
  - Beat (in_valid=1) with ch_idx==0: add_ena=0, add_sel_zero=0 (load).
  - Beat with ch_idx>0: add_ena=1, add_sel_zero=0 (accumulate).
  - No beat: hold rule; ch_idx unchanged.
  - Beat with ch_idx==num_ch-1: ch_idx<=0, go to RES.
  - Beat otherwise: ch_idx<=ch_idx+1.
- RES:
  - out_valid=1, in_ready=0, hold rule applies.
  - out_last = (tile_idx==num_tiles-1).
  - out_ready=1 and out_last=0: tile_idx<=tile_idx+1, go to ACC.
  - out_ready=1 and out_last=1: go to IDLE; done=1 in the following cycle only.
  - out_ready=0: remain in RES; adder value and out_valid held.
- Latency:
  - out_valid rises in the cycle after the clock edge that captured the final beat.
  - num_ch=1: every beat is a load, followed directly by RES.
  - Minimum per tile: num_ch+1 cycles.
- start outside IDLE (including in the done cycle, which is already IDLE, i.e. the done cycle accepts start): ignored while busy=1; latched config is not modified.
- Width rules:
  - Counters compare against latched config, never live cfg_* inputs.
  - No counter wraps within a command because config values are at most 2^W-1.
- The controller never inspects data; sum width and overflow belong to the adder.

Optional Feature:
- Macro: ACC_SEQ_PERF_EN.
- Defined:
  - stall_cnt increments in each ACC cycle with in_valid=0 and each RES cycle with out_ready=0.
  - Saturates at 0xFFFF_FFFF.
  - Cleared to 0 on the cycle a start is accepted; holds its value in IDLE.
- Undefined: stall_cnt is constant 0 and the counter logic is absent.

Test Plan:
- num_ch=3, tiles=1, in_valid high 3 cycles, out_ready=1 -> add_ena 0,1,1 with add_sel_zero 0. Next cycle out_valid=1, out_last=1; adder holds sum of 3 vectors (e.g. 1+2+3=6 per lane); done pulse one cycle after the handshake; busy then 0.
- num_ch=4, beats with 2 idle gaps -> gap cycles add_ena=1, add_sel_zero=1, in_ready=1, ch_idx frozen. Sum equals the sum of the 4 vectors; out_valid 1 cycle after the 4th beat.
- num_ch=1, tiles=3, out_ready low 2 cycles per tile -> out_valid held 3 cycles each, in_ready=0 during RES. tile_idx 0,1,2; out_last only on tile 2; exactly one done.
- start with cfg_num_ch=0 -> stays IDLE, busy=0, no done. start pulse mid-command with new cfg -> ignored, tile/ch counts unchanged.
- rstn=0 in ACC at ch_idx=2 -> next cycle IDLE, all outputs at reset values; a new start then begins at ch_idx=0 with a load beat (add_ena=0).
- ACC_SEQ_PERF_EN defined, num_ch=2, tiles=1, 2 input gaps + 3 out_ready-low cycles -> stall_cnt=5. Next accepted start clears it to 0. Undefined: stall_cnt stays 0.
